vram_arb: RTL and testbench
===========================

Name: vram_arb

Overview:
Arbiter and sequencer for the 16x64K VRAM port, shared by three requesters: video generator, blitter and host register interface (SPI command path).
- Video owns every slot where `blit_cycle_i` is low.
- Slots where `blit_cycle_i` is high are shared round-robin between host and blitter.
- Sits between `video_gen`/`blitter`/host logic and the `vram` instance, replacing the ad-hoc 2:1 mux.
- All VRAM-side outputs are registered.

Parameters:
- `ADDR_W`, 16, VRAM word address width.
- `DATA_W`, 16, VRAM word width.

Ports:
- `clk` in 1: pixel clock.
- `reset_i` in 1: reset; synchronous and active-high.
- `blit_cycle_i` in 1: from `video_gen`; 1 = slot free for host/blitter, 0 = video slot.
- `vgen_sel_i` in 1: video requests a read this slot.
- `vgen_addr_i` in `ADDR_W`: video read address.
- `vgen_data_o` out `DATA_W`: video read data.
- `blit_req_i` in 1: blitter access request; held until ack.
- `blit_wr_i` in 1: 1 = write, 0 = read.
- `blit_addr_i` in `ADDR_W`: blitter address.
- `blit_data_i` in `DATA_W`: blitter write data.
- `blit_ack_o` out 1: one-cycle completion pulse.
- `blit_data_o` out `DATA_W`: blitter read data, valid with ack.
- `host_req_i`, `host_wr_i`, `host_addr_i`, `host_data_i`, `host_ack_o`, `host_data_o`: same semantics and widths as the `blit_*` group.
- `vram_sel_o` out 1: to `vram` `sel`.
- `vram_wr_o` out 1: to `vram` `wr_en`.
- `vram_addr_o` out `ADDR_W`: to `vram` `address_in`.
- `vram_data_o` out `DATA_W`: to `vram` `data_in`.
- `vram_data_i` in `DATA_W`: from `vram` `data_out`; valid one cycle after a read is presented.

Behaviour:
- **Reset values.** All outputs 0. Round-robin pointer `rr` = 0 (host next). Busy flags and in-flight pipeline cleared.
- **Reset mid-operation.** Any in-flight access is discarded and no ack is issued for it. Requesters re-request after reset.
- **Arbitration (cycle N), evaluated every cycle:**
  - `blit_cycle_i`=0: grant video if `vgen_sel_i`=1, otherwise idle. Video is never stalled.
  - `blit_cycle_i`=1: eligible = `req_i` && !`busy`, per requester.
    - Both eligible: grant `rr` owner, then toggle `rr` to the other requester.
    - One eligible: grant it; `rr` is set to the other requester.
    - Neither eligible: idle. `vram_sel_o`=0, `vram_wr_o`=0; address and data hold their previous values.
  - `vgen_sel_i` is ignored while `blit_cycle_i`=1.
- **Issue (cycle N+1).** The granted request is registered onto `vram_sel_o`/`vram_wr_o`/`vram_addr_o`/`vram_data_o`. `vram_wr_o` is 0 for video grants.
- **Busy flag.** Set in cycle N+1 on grant. Cleared in the same cycle the requester's ack is asserted. A requester can therefore never hold two accesses in flight.
- **Write completion.** `ack_o` pulses in cycle N+2 (VRAM committed the write at the N+1 edge). Read data output is unchanged.
- **Read completion.** `vram_data_i` is valid in cycle N+2. It is registered into the owner's `data_o`, and for host/blitter `ack_o` pulses in cycle N+3.
  - Video read latency is fixed at 3 cycles: `vgen_addr_i` at N gives `vgen_data_o` valid at N+3. `video_gen` compensates.
  - `data_o` registers hold their value until the next read completes for that owner.
- **Owner tracking.** A 2-stage owner pipeline (2-bit tag: none / video / blit / host, plus a write bit) follows each access. It steers data and ack. No combinational path from `vram_data_i` to ack.
- **Requester rules.**
  - Hold `req`/`wr`/`addr`/`data` stable from assert until ack.
  - `req` may stay high in the ack cycle to request the next access. It is re-eligible in the cycle after ack, since busy was cleared in the ack cycle.
  - Dropping `req` before ack is illegal. The arbiter completes the access anyway.
- **Throughput.** One access per requester every 3 cycles (write) or 4 cycles (read) when uncontended. Slots are pipelined, so host and blitter can be in flight simultaneously.
- **Address/data width.** No arithmetic; straight registered mux, no truncation.

Optional Feature:
`VRAM_ARB_HOST_PRIO_EN`
- Defined: host has fixed priority over blitter in free slots. `rr` is unused (held 0). Blitter is granted only when host is not eligible.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then `blit_cycle_i`=0, `vgen_sel_i`=1, `vgen_addr_i`=0x1234 at N -> `vram_sel_o`=1, `vram_addr_o`=0x1234, `vram_wr_o`=0 at N+1. Model returns 0xBEEF at N+2 -> `vgen_data_o`=0xBEEF at N+3. No acks.
2. `blit_cycle_i`=1, host write addr 0x0010 data 0xA5A5 -> `vram_wr_o`=1 with those values at N+1; `host_ack_o` one-cycle pulse at N+2; `blit_ack_o` stays 0.
3. `blit_cycle_i`=1, host and blitter both request reads (0x0100, 0x0200) from reset -> host issued at N+1, blitter at N+2. `host_ack_o` at N+3 and `blit_ack_o` at N+4, each with the matching model data.
4. `blit_cycle_i` alternating 0/1, blitter `req` held -> blitter issued only in free slots; video address issued in every video slot; no ack before its data.
5. Host read granted, `reset_i` pulsed at N+1 -> no `host_ack_o` ever; all outputs 0 at N+2; new request after reset completes normally.
6. With `VRAM_ARB_HOST_PRIO_EN`: host `req` held continuously plus blitter `req` -> blitter granted only in free slots while host is busy (between its grant and ack); never granted ahead of an eligible host.

Source files
------------

// File: rtl/vram_arb.sv
// ---------------------------------------------------------------------------
// vram_arb -- arbiter and sequencer for the shared 16x64K VRAM port.
//
// Three requesters share one VRAM port:
//   * video generator : owns every slot where blit_cycle_i is low, never stalls
//   * blitter         : shares blit_cycle_i-high slots with the host
//   * host (SPI path) : shares blit_cycle_i-high slots with the blitter
//
// Timeline for a grant decided in cycle N:
//   N+1 : access presented on vram_* (registered)
//   N+2 : write ack pulse, or read data arrives on vram_data_i
//   N+3 : read data registered on <owner>_data_o (+ ack for host/blitter)
//
// Ports:
//   clk, reset_i                     clock, synchronous active-high reset
//   blit_cycle_i                     1 = free slot, 0 = video slot
//   vgen_sel_i/vgen_addr_i           video read request / address
//   vgen_data_o                      video read data (3-cycle latency)
//   blit_req_i/wr_i/addr_i/data_i    blitter request group
//   blit_ack_o/blit_data_o           blitter completion pulse / read data
//   host_*                           same as blit_* for the host
//   vram_sel_o/wr_o/addr_o/data_o    registered VRAM command
//   vram_data_i                      VRAM read data, one cycle after the read
//
// Handshake (host and blitter): req/wr/addr/data are held stable from the
// cycle req rises until the cycle ack is seen. ack is a single-cycle pulse;
// read data is valid on data_o in the ack cycle and held until the next read
// for that owner completes. req may stay high through ack to ask for the next
// access, which becomes eligible the cycle after ack.
//
// Build option: define VRAM_ARB_HOST_PRIO_EN to give the host fixed priority
// over the blitter in free slots (round-robin pointer then stays 0).
// ---------------------------------------------------------------------------
module vram_arb #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              blit_cycle_i,
    input  logic              vgen_sel_i,
    input  logic [ADDR_W-1:0] vgen_addr_i,
    output logic [DATA_W-1:0] vgen_data_o,
    input  logic              blit_req_i,
    input  logic              blit_wr_i,
    input  logic [ADDR_W-1:0] blit_addr_i,
    input  logic [DATA_W-1:0] blit_data_i,
    output logic              blit_ack_o,
    output logic [DATA_W-1:0] blit_data_o,
    input  logic              host_req_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_data_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_BLIT = 2'd2,
        OWN_HOST = 2'd3
    } owner_t;

    // rr: 0 = host goes next on a tie, 1 = blitter goes next.
    logic              r_rr;
    logic              r_host_busy;
    logic              r_blit_busy;
    // Owner pipeline: stage 1 tracks the access on the VRAM port,
    // stage 2 tracks the cycle its read data is on vram_data_i.
    owner_t            r_s1_own;
    logic              r_s1_wr;
    owner_t            r_s2_own;
    logic              r_s2_wr;
    logic              r_vram_sel;
    logic              r_vram_wr;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_data;
    logic [DATA_W-1:0] r_vgen_data;
    logic [DATA_W-1:0] r_blit_data;
    logic [DATA_W-1:0] r_host_data;
    logic              r_blit_ack;
    logic              r_host_ack;

    logic              w_host_elig;
    logic              w_blit_elig;
    owner_t            w_grant;
    logic              w_rr_next;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_host_ack_next;
    logic              w_blit_ack_next;

    // Busy stays set through the ack cycle, so a req held high across ack
    // is not re-granted until the following cycle.
    always_comb begin
        w_host_elig = host_req_i && !r_host_busy;
        w_blit_elig = blit_req_i && !r_blit_busy;
        w_grant     = OWN_NONE;
        w_rr_next   = r_rr;
        if (!blit_cycle_i) begin
            if (vgen_sel_i) begin
                w_grant = OWN_VID;
            end
        end else begin
`ifdef VRAM_ARB_HOST_PRIO_EN
            w_rr_next = 1'b0;
            if (w_host_elig) begin
                w_grant = OWN_HOST;
            end else if (w_blit_elig) begin
                w_grant = OWN_BLIT;
            end
`else
            if (w_host_elig && w_blit_elig) begin
                w_grant   = r_rr ? OWN_BLIT : OWN_HOST;
                w_rr_next = !r_rr;
            end else if (w_host_elig) begin
                w_grant   = OWN_HOST;
                w_rr_next = 1'b1;
            end else if (w_blit_elig) begin
                w_grant   = OWN_BLIT;
                w_rr_next = 1'b0;
            end
`endif
        end
    end

    // Command mux; fields not driven by the winner hold their last value.
    always_comb begin
        w_wr   = 1'b0;
        w_addr = r_vram_addr;
        w_data = r_vram_data;
        case (w_grant)
            OWN_VID: begin
                w_addr = vgen_addr_i;
            end
            OWN_BLIT: begin
                w_wr   = blit_wr_i;
                w_addr = blit_addr_i;
                w_data = blit_data_i;
            end
            OWN_HOST: begin
                w_wr   = host_wr_i;
                w_addr = host_addr_i;
                w_data = host_data_i;
            end
            default: ;
        endcase
    end

    // Writes ack one stage after issue; reads ack when their data is
    // registered. Both come from the owner pipeline, never from vram_data_i.
    always_comb begin
        w_host_ack_next = ((r_s1_own == OWN_HOST) && r_s1_wr) ||
                          ((r_s2_own == OWN_HOST) && !r_s2_wr);
        w_blit_ack_next = ((r_s1_own == OWN_BLIT) && r_s1_wr) ||
                          ((r_s2_own == OWN_BLIT) && !r_s2_wr);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_rr        <= 1'b0;
            r_host_busy <= 1'b0;
            r_blit_busy <= 1'b0;
            r_s1_own    <= OWN_NONE;
            r_s1_wr     <= 1'b0;
            r_s2_own    <= OWN_NONE;
            r_s2_wr     <= 1'b0;
            r_vram_sel  <= 1'b0;
            r_vram_wr   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
            r_vgen_data <= '0;
            r_blit_data <= '0;
            r_host_data <= '0;
            r_blit_ack  <= 1'b0;
            r_host_ack  <= 1'b0;
        end else begin
            r_rr        <= w_rr_next;
            r_vram_sel  <= (w_grant != OWN_NONE);
            r_vram_wr   <= w_wr;
            r_vram_addr <= w_addr;
            r_vram_data <= w_data;
            r_s1_own    <= w_grant;
            r_s1_wr     <= w_wr;
            r_s2_own    <= r_s1_own;
            r_s2_wr     <= r_s1_wr;
            r_host_ack  <= w_host_ack_next;
            r_blit_ack  <= w_blit_ack_next;

            if (w_grant == OWN_HOST) begin
                r_host_busy <= 1'b1;
            end else if (r_host_ack) begin
                r_host_busy <= 1'b0;
            end
            if (w_grant == OWN_BLIT) begin
                r_blit_busy <= 1'b1;
            end else if (r_blit_ack) begin
                r_blit_busy <= 1'b0;
            end

            if (r_s2_own == OWN_VID) begin
                r_vgen_data <= vram_data_i;
            end
            if ((r_s2_own == OWN_HOST) && !r_s2_wr) begin
                r_host_data <= vram_data_i;
            end
            if ((r_s2_own == OWN_BLIT) && !r_s2_wr) begin
                r_blit_data <= vram_data_i;
            end
        end
    end

    assign vram_sel_o  = r_vram_sel;
    assign vram_wr_o   = r_vram_wr;
    assign vram_addr_o = r_vram_addr;
    assign vram_data_o = r_vram_data;
    assign vgen_data_o = r_vgen_data;
    assign host_ack_o  = r_host_ack;
    assign host_data_o = r_host_data;
    assign blit_ack_o  = r_blit_ack;
    assign blit_data_o = r_blit_data;

endmodule

// File: tb/tb_vram_arb.sv
// ---------------------------------------------------------------------------
// tb_vram_arb -- bench for vram_arb.
// A VRAM model answers the DUT's port; a slot-level model predicts every
// registered output cycle by cycle from the arbitration rules, and directed
// checks pin the documented scenarios with literal values.
// ---------------------------------------------------------------------------
module tb_vram_arb;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W_NONE = 0;
  localparam int W_VID  = 1;
  localparam int W_BLIT = 2;
  localparam int W_HOST = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic          blit_cycle_i = 1'b0;
  logic          vgen_sel_i = 1'b0;
  logic [AW-1:0] vgen_addr_i = '0;
  logic [DW-1:0] vgen_data_o;
  logic          blit_req_i = 1'b0;
  logic          blit_wr_i = 1'b0;
  logic [AW-1:0] blit_addr_i = '0;
  logic [DW-1:0] blit_data_i = '0;
  logic          blit_ack_o;
  logic [DW-1:0] blit_data_o;
  logic          host_req_i = 1'b0;
  logic          host_wr_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_data_i = '0;
  logic          host_ack_o;
  logic [DW-1:0] host_data_o;
  logic          vram_sel_o;
  logic          vram_wr_o;
  logic [AW-1:0] vram_addr_o;
  logic [DW-1:0] vram_data_o;
  logic [DW-1:0] vram_data_i = '0;

  vram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_i(reset_i), .blit_cycle_i(blit_cycle_i),
    .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i), .vgen_data_o(vgen_data_o),
    .blit_req_i(blit_req_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
    .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o), .blit_data_o(blit_data_o),
    .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_ack_o(host_ack_o), .host_data_o(host_data_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- VRAM model (environment) ----------------
  logic [DW-1:0] vmem [logic [AW-1:0]];
  logic [DW-1:0] emem [logic [AW-1:0]];
  logic [DW-1:0] rd_next = '0;

  function automatic logic [DW-1:0] vmem_rd(input logic [AW-1:0] a);
    if (vmem.exists(a)) return vmem[a];
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] emem_rd(input logic [AW-1:0] a);
    if (emem.exists(a)) return emem[a];
    return a ^ 16'h5A5A;
  endfunction

  always @(negedge clk) begin
    if (vram_sel_o === 1'b1 && vram_wr_o === 1'b1) vmem[vram_addr_o] = vram_data_o;
    if (vram_sel_o === 1'b1 && vram_wr_o === 1'b0) rd_next = vmem_rd(vram_addr_o);
    else rd_next = 16'($urandom);
  end

  // Read data appears for the whole cycle after the read was presented.
  always @(posedge clk) begin
    #1;
    vram_data_i = rd_next;
  end

  // ---------------- slot model ----------------
  bit            model_on = 0;
  int            m_rr = 0;
  int            host_free = 0;
  int            blit_free = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  logic          e_sel [8];
  logic          e_wr [8];
  logic [AW-1:0] e_addr [8];
  logic [DW-1:0] e_wdata [8];
  bit            a_h [8];
  bit            a_b [8];
  bit            u_h [8];
  bit            u_b [8];
  bit            u_v [8];
  logic [DW-1:0] u_h_val [8];
  logic [DW-1:0] u_b_val [8];
  logic [DW-1:0] u_v_val [8];
  logic [DW-1:0] h_host = '0;
  logic [DW-1:0] h_blit = '0;
  logic [DW-1:0] h_vgen = '0;

  task automatic model_step();
    int who;
    bit he;
    bit be;
    bit rwr;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdat;
    int n1;
    int n2;
    int n3;
    n1 = (cyc + 1) % 8;
    n2 = (cyc + 2) % 8;
    n3 = (cyc + 3) % 8;
    if (reset_i === 1'b1) begin
      model_on = 1;
      m_rr = 0;
      host_free = 0;
      blit_free = 0;
      last_addr = '0;
      last_data = '0;
      h_host = '0;
      h_blit = '0;
      h_vgen = '0;
      for (int i = 0; i < 8; i++) begin
        a_h[i] = 0; a_b[i] = 0; u_h[i] = 0; u_b[i] = 0; u_v[i] = 0;
      end
      e_sel[n1] = 0; e_wr[n1] = 0; e_addr[n1] = '0; e_wdata[n1] = '0;
      return;
    end
    who = W_NONE;
    if (!blit_cycle_i) begin
      if (vgen_sel_i) who = W_VID;
    end else begin
      he = host_req_i && (cyc >= host_free);
      be = blit_req_i && (cyc >= blit_free);
`ifdef VRAM_ARB_HOST_PRIO_EN
      if (he) who = W_HOST;
      else if (be) who = W_BLIT;
`else
      if (he && be) begin
        who = (m_rr == 0) ? W_HOST : W_BLIT;
        m_rr = 1 - m_rr;
      end else if (he) begin
        who = W_HOST;
        m_rr = 1;
      end else if (be) begin
        who = W_BLIT;
        m_rr = 0;
      end
`endif
    end
    e_sel[n1] = (who != W_NONE);
    e_wr[n1] = 0;
    if (who == W_VID) begin
      last_addr = vgen_addr_i;
      u_v[n3] = 1;
      u_v_val[n3] = emem_rd(vgen_addr_i);
    end else if (who == W_HOST || who == W_BLIT) begin
      rwr  = (who == W_HOST) ? host_wr_i : blit_wr_i;
      radr = (who == W_HOST) ? host_addr_i : blit_addr_i;
      rdat = (who == W_HOST) ? host_data_i : blit_data_i;
      last_addr = radr;
      last_data = rdat;
      e_wr[n1] = rwr;
      if (rwr) begin
        emem[radr] = rdat;
        if (who == W_HOST) begin a_h[n2] = 1; host_free = cyc + 3; end
        else begin a_b[n2] = 1; blit_free = cyc + 3; end
      end else if (who == W_HOST) begin
        a_h[n3] = 1; u_h[n3] = 1; u_h_val[n3] = emem_rd(radr); host_free = cyc + 4;
      end else begin
        a_b[n3] = 1; u_b[n3] = 1; u_b_val[n3] = emem_rd(radr); blit_free = cyc + 4;
      end
    end
    e_addr[n1] = last_addr;
    e_wdata[n1] = last_data;
  endtask

  // Compare process: outputs of this cycle, then advance the model.
  always @(negedge clk) begin : cmp
    int s;
    s = cyc % 8;
    if (model_on) begin
      if (u_h[s]) h_host = u_h_val[s];
      if (u_b[s]) h_blit = u_b_val[s];
      if (u_v[s]) h_vgen = u_v_val[s];
      check("m_vram_sel", vram_sel_o, e_sel[s]);
      check("m_vram_wr", vram_wr_o, e_wr[s]);
      check("m_vram_addr", vram_addr_o, e_addr[s]);
      check("m_vram_data", vram_data_o, e_wdata[s]);
      check("m_host_ack", host_ack_o, a_h[s]);
      check("m_blit_ack", blit_ack_o, a_b[s]);
      check("m_host_data", host_data_o, h_host);
      check("m_blit_data", blit_data_o, h_blit);
      check("m_vgen_data", vgen_data_o, h_vgen);
      a_h[s] = 0; a_b[s] = 0; u_h[s] = 0; u_b[s] = 0; u_v[s] = 0;
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    host_req_i = 0;
    blit_req_i = 0;
    vgen_sel_i = 0;
    reset_i = 1;
    tick();
    tick();
    reset_i = 0;
  endtask

  task automatic host_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit last);
    int n;
    host_wr_i = wr; host_addr_i = a; host_data_i = d; host_req_i = 1;
    n = 0;
    do begin tick(); n++; end while (host_ack_o !== 1'b1 && n < 16);
    tests++;
    if (host_ack_o !== 1'b1) begin
      fails++;
      $display("FAIL host_ack_timeout: no ack after %0d cycles, expected ack", n);
    end
    if (last) host_req_i = 0;
  endtask

  task automatic blit_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit last);
    int n;
    blit_wr_i = wr; blit_addr_i = a; blit_data_i = d; blit_req_i = 1;
    n = 0;
    do begin tick(); n++; end while (blit_ack_o !== 1'b1 && n < 16);
    tests++;
    if (blit_ack_o !== 1'b1) begin
      fails++;
      $display("FAIL blit_ack_timeout: no ack after %0d cycles, expected ack", n);
    end
    if (last) blit_req_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    vmem[16'h1234] = 16'hBEEF; emem[16'h1234] = 16'hBEEF;
    vmem[16'h0100] = 16'h1111; emem[16'h0100] = 16'h1111;
    vmem[16'h0200] = 16'h2222; emem[16'h0200] = 16'h2222;

    // Reset state and video read.
    reset_dut();
    @(negedge clk);
    check("rst_sel", vram_sel_o, 0);
    check("rst_addr", vram_addr_o, 0);
    check("rst_vgen_data", vgen_data_o, 0);
    check("rst_host_ack", host_ack_o, 0);
    check("rst_blit_data", blit_data_o, 0);
    tick();
    blit_cycle_i = 0; vgen_sel_i = 1; vgen_addr_i = 16'h1234;
    tick();
    vgen_sel_i = 0;
    @(negedge clk);
    check("t1_sel", vram_sel_o, 1);
    check("t1_addr", vram_addr_o, 16'h1234);
    check("t1_wr", vram_wr_o, 0);
    tick();
    tick();
    @(negedge clk);
    check("t1_vgen_data", vgen_data_o, 16'hBEEF);
    check("t1_no_ack", {host_ack_o, blit_ack_o}, 0);

    // Host write.
    tick();
    blit_cycle_i = 1;
    host_wr_i = 1; host_addr_i = 16'h0010; host_data_i = 16'hA5A5; host_req_i = 1;
    tick();
    @(negedge clk);
    check("t2_sel", vram_sel_o, 1);
    check("t2_wr", vram_wr_o, 1);
    check("t2_addr", vram_addr_o, 16'h0010);
    check("t2_data", vram_data_o, 16'hA5A5);
    tick();
    host_req_i = 0;
    @(negedge clk);
    check("t2_host_ack", host_ack_o, 1);
    check("t2_blit_ack", blit_ack_o, 0);
    tick();
    @(negedge clk);
    check("t2_ack_pulse", host_ack_o, 0);
    check("t2_idle_sel", vram_sel_o, 0);
    check("t2_hold_addr", vram_addr_o, 16'h0010);
    check("t2_hold_data", vram_data_o, 16'hA5A5);

    // Contended reads from reset: host first, then blitter.
    tick();
    reset_dut();
    blit_cycle_i = 1;
    host_wr_i = 0; host_addr_i = 16'h0100; host_req_i = 1;
    blit_wr_i = 0; blit_addr_i = 16'h0200; blit_req_i = 1;
    tick();
    @(negedge clk);
    check("t3_host_issue", {vram_sel_o, vram_wr_o, vram_addr_o}, {2'b10, 16'h0100});
    tick();
    @(negedge clk);
    check("t3_blit_issue", {vram_sel_o, vram_wr_o, vram_addr_o}, {2'b10, 16'h0200});
    tick();
    host_req_i = 0;
    @(negedge clk);
    check("t3_host_ack", host_ack_o, 1);
    check("t3_host_data", host_data_o, 16'h1111);
    check("t3_blit_early", blit_ack_o, 0);
    tick();
    blit_req_i = 0;
    @(negedge clk);
    check("t3_blit_ack", blit_ack_o, 1);
    check("t3_blit_data", blit_data_o, 16'h2222);
    check("t3_host_pulse", host_ack_o, 0);

    // Reset while a host read is in flight.
    tick();
    reset_dut();
    blit_cycle_i = 1;
    host_wr_i = 0; host_addr_i = 16'h0100; host_req_i = 1;
    tick();
    reset_i = 1;
    @(negedge clk);
    check("t5_issue", {vram_sel_o, vram_addr_o}, {1'b1, 16'h0100});
    tick();
    reset_i = 0;
    @(negedge clk);
    check("t5_rst_sel", vram_sel_o, 0);
    check("t5_rst_addr", vram_addr_o, 0);
    check("t5_rst_ack", host_ack_o, 0);
    check("t5_rst_hdata", host_data_o, 0);
    tick();
    @(negedge clk);
    check("t5_no_stale_ack", host_ack_o, 0);
    check("t5_reissue", {vram_sel_o, vram_addr_o}, {1'b1, 16'h0100});
    tick();
    @(negedge clk);
    check("t5_no_ack_n4", host_ack_o, 0);
    tick();
    host_req_i = 0;
    @(negedge clk);
    check("t5_new_ack", host_ack_o, 1);
    check("t5_new_data", host_data_o, 16'h1111);

    // Alternating video / free slots with the blitter held requesting.
    tick();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          blit_cycle_i = i[0];
          vgen_sel_i = 1;
          vgen_addr_i = 16'h3000 + 16'(i);
          tick();
        end
      end
      begin
        blit_op(0, 16'h0200, 16'h0000, 0);
        blit_op(1, 16'h0070, 16'h7777, 0);
        blit_op(0, 16'h0070, 16'h0000, 1);
      end
    join
    vgen_sel_i = 0;
    blit_cycle_i = 1;

    // Mixed host/blitter traffic in free slots.
    tick();
    fork
      begin
        host_op(1, 16'h0040, 16'hCAFE, 0);
        host_op(0, 16'h0040, 16'h0000, 0);
        host_op(1, 16'h0050, 16'h1357, 0);
        host_op(0, 16'h0200, 16'h0000, 1);
      end
      begin
        blit_op(0, 16'h0040, 16'h0000, 0);
        blit_op(1, 16'h0060, 16'h2468, 0);
        blit_op(0, 16'h0060, 16'h0000, 0);
        blit_op(1, 16'h0100, 16'h9999, 1);
      end
    join

    // Host streaming writes while the blitter requests reads.
    tick();
    fork
      begin
        host_op(1, 16'h0800, 16'h0801, 0);
        host_op(1, 16'h0801, 16'h0802, 0);
        host_op(1, 16'h0802, 16'h0803, 0);
        host_op(1, 16'h0803, 16'h0804, 1);
      end
      begin
        blit_op(0, 16'h0801, 16'h0000, 0);
        blit_op(0, 16'h0100, 16'h0000, 1);
      end
    join

    repeat (6) tick();
    @(negedge clk);
    check("end_blit_data", blit_data_o, 16'h9999);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
